// File: rtl/buffer_arb_pkg.sv
// Shared types and constants for the endpoint buffer arbiter.
package buffer_arb_pkg;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      LOCKED = 2'd1,
      FLUSH  = 2'd2,
      SETTLE = 2'd3
   } arb_state_t;

   localparam logic OP_STORE  = 1'b0;
   localparam logic OP_GET    = 1'b1;
   localparam int   BUF_DEPTH = 64;

   // Saturating 16-bit increment used by the grant statistics.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         return value;
      end else begin
         return value + 16'd1;
      end
   endfunction

endpackage

// File: rtl/buffer_arbiter_rr.sv
// Two-requester round-robin: bit 0 = host, bit 1 = USB; pointer names the preferred side.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       ptr
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // After a grant the other side becomes preferred.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         ptr <= gnt[0];
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/buffer_arbiter.sv
// Host/USB access arbiter for the 64-byte endpoint buffer with clear/flush sequencing and USB lock.
// Optional grant statistics are built when BUFFER_ARB_STATS_EN is defined.
module buffer_arbiter
   import buffer_arb_pkg::*;
#(
   parameter int DEPTH        = BUF_DEPTH,
   parameter int OCC_W        = 7,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             host_req,
   input  logic             host_op,
   input  logic [7:0]       host_wdata,
   output logic             host_gnt,
   input  logic             host_clear,
   input  logic             usb_req,
   input  logic             usb_op,
   input  logic [7:0]       usb_wdata,
   output logic             usb_gnt,
   input  logic             usb_flush,
   input  logic             usb_lock,
   input  logic [OCC_W-1:0] buffer_occupancy,
   output logic             buf_store,
   output logic             buf_get,
   output logic [7:0]       buf_wdata,
   output logic             buf_flush,
   output logic             lock_err,
   output logic [15:0]      host_gnt_cnt,
   output logic [15:0]      usb_gnt_cnt
);

   localparam int                WAIT_W    = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(LOCK_TIMEOUT);
   localparam logic [OCC_W-1:0]  DEPTH_V   = OCC_W'(DEPTH);

   arb_state_t        state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              lock_ignore;

   logic       clear_req;
   logic       store_ok;
   logic       get_ok;
   logic       host_elig;
   logic       usb_elig;
   logic       lock_active;
   logic       grant_window;
   logic       host_blocked;
   logic       timeout;
   logic       stay_locked;
   logic [1:0] rr_req;
   logic [1:0] rr_gnt;
   logic       rr_ptr;

   // Request qualification: occupancy gating, lock masking and grant suppression.
   always_comb begin
      clear_req    = host_clear | usb_flush;
      store_ok     = (buffer_occupancy < DEPTH_V);
      get_ok       = (buffer_occupancy != {OCC_W{1'b0}});
      host_elig    = host_req & ((host_op == OP_STORE) ? store_ok : get_ok);
      usb_elig     = usb_req & ((usb_op == OP_STORE) ? store_ok : get_ok);
      lock_active  = usb_lock & ~lock_ignore;
      grant_window = ~rst & ~clear_req & ((state == ARB) | (state == LOCKED));
      host_blocked = (state == LOCKED) | lock_active;
      rr_req       = {usb_elig & grant_window, host_elig & grant_window & ~host_blocked};
      timeout      = ~clear_req & (state == LOCKED) & host_req
                   & ((wait_cnt + WAIT_W'(1)) == TIMEOUT_V);
      stay_locked  = ~clear_req & (state == LOCKED) & usb_lock & ~timeout;
   end

   rr_arbiter_2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (rr_req),
      .advance (grant_window),
      .gnt     (rr_gnt),
      .ptr     (rr_ptr)
   );

   // Grants and buffer strobes follow the request in the same cycle.
   always_comb begin
      host_gnt  = rr_gnt[0];
      usb_gnt   = rr_gnt[1];
      buf_store = (rr_gnt[0] & (host_op == OP_STORE)) | (rr_gnt[1] & (usb_op == OP_STORE));
      buf_get   = (rr_gnt[0] & (host_op == OP_GET))   | (rr_gnt[1] & (usb_op == OP_GET));
      if (rr_gnt[0] && (host_op == OP_STORE)) begin
         buf_wdata = host_wdata;
      end else if (rr_gnt[1] && (usb_op == OP_STORE)) begin
         buf_wdata = usb_wdata;
      end else begin
         buf_wdata = 8'h00;
      end
      buf_flush = ~rst & (state == FLUSH);
   end

   // Sequencer: clear/flush beats lock, lock beats plain arbitration.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ARB;
         wait_cnt    <= {WAIT_W{1'b0}};
         lock_ignore <= 1'b0;
         lock_err    <= 1'b0;
      end else begin
         if (clear_req) begin
            state <= FLUSH;
         end else begin
            case (state)
               ARB:     state <= lock_active ? LOCKED : ARB;
               LOCKED:  state <= (timeout || !usb_lock) ? ARB : LOCKED;
               FLUSH:   state <= SETTLE;
               SETTLE:  state <= lock_active ? LOCKED : ARB;
               default: state <= ARB;
            endcase
         end

         // A timed-out lock stays ignored until the USB side releases it.
         if (!usb_lock) begin
            lock_ignore <= 1'b0;
         end else if (timeout) begin
            lock_ignore <= 1'b1;
         end else begin
            lock_ignore <= lock_ignore;
         end

         if (host_clear) begin
            lock_err <= 1'b0;
         end else if (timeout) begin
            lock_err <= 1'b1;
         end else begin
            lock_err <= lock_err;
         end

         if (stay_locked && host_req && !rr_gnt[0]) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end else if (stay_locked && !rr_gnt[0]) begin
            wait_cnt <= wait_cnt;
         end else begin
            wait_cnt <= {WAIT_W{1'b0}};
         end
      end
   end

`ifdef BUFFER_ARB_STATS_EN
   logic [15:0] host_cnt;
   logic [15:0] usb_cnt;

   // Saturating per-side grant counters, cleared by reset or host clear.
   always_ff @(posedge clk) begin
      if (rst || host_clear) begin
         host_cnt <= 16'h0000;
         usb_cnt  <= 16'h0000;
      end else begin
         host_cnt <= rr_gnt[0] ? sat_inc16(host_cnt) : host_cnt;
         usb_cnt  <= rr_gnt[1] ? sat_inc16(usb_cnt) : usb_cnt;
      end
   end

   assign host_gnt_cnt = host_cnt;
   assign usb_gnt_cnt  = usb_cnt;
`else
   assign host_gnt_cnt = 16'h0000;
   assign usb_gnt_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_buffer_arbiter.sv
// Scoreboard bench for buffer_arbiter; statistics checks follow BUFFER_ARB_STATS_EN.
module tb_buffer_arbiter;
   import buffer_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        host_req = 1'b0;
   logic        host_op = 1'b0;
   logic [7:0]  host_wdata = 8'h00;
   logic        host_gnt;
   logic        host_clear = 1'b0;
   logic        usb_req = 1'b0;
   logic        usb_op = 1'b0;
   logic [7:0]  usb_wdata = 8'h00;
   logic        usb_gnt;
   logic        usb_flush = 1'b0;
   logic        usb_lock = 1'b0;
   logic [6:0]  buffer_occupancy = 7'd0;
   logic        buf_store;
   logic        buf_get;
   logic [7:0]  buf_wdata;
   logic        buf_flush;
   logic        lock_err;
   logic [15:0] host_gnt_cnt;
   logic [15:0] usb_gnt_cnt;

   int errors = 0;
   int checks = 0;
   logic [11:0] exp_q[$];
   logic [11:0] mon_act;
   logic [11:0] mon_exp;

   always #5 clk = ~clk;

   buffer_arbiter dut (
      .clk(clk), .rst(rst),
      .host_req(host_req), .host_op(host_op), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_clear(host_clear),
      .usb_req(usb_req), .usb_op(usb_op), .usb_wdata(usb_wdata),
      .usb_gnt(usb_gnt), .usb_flush(usb_flush), .usb_lock(usb_lock),
      .buffer_occupancy(buffer_occupancy),
      .buf_store(buf_store), .buf_get(buf_get), .buf_wdata(buf_wdata),
      .buf_flush(buf_flush), .lock_err(lock_err),
      .host_gnt_cnt(host_gnt_cnt), .usb_gnt_cnt(usb_gnt_cnt)
   );

   // Event encoding: {usb_gnt, host_gnt, buf_get, buf_store, buf_wdata}
   function automatic logic [11:0] ev_host_store(input logic [7:0] d);
      return {2'b01, 2'b01, d};
   endfunction
   function automatic logic [11:0] ev_host_get();
      return {2'b01, 2'b10, 8'h00};
   endfunction
   function automatic logic [11:0] ev_usb_store(input logic [7:0] d);
      return {2'b10, 2'b01, d};
   endfunction

   // Every buffer access is popped against the expected queue.
   always @(negedge clk) begin
      if (host_gnt | usb_gnt | buf_store | buf_get) begin
         mon_act = {usb_gnt, host_gnt, buf_get, buf_store, buf_wdata};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected actual=%h required=no access", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL sb_access actual=%h required=%h", mon_act, mon_exp);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      host_req = 1'b1; host_op = OP_GET; usb_req = 1'b1; usb_op = OP_STORE;
      buffer_occupancy = 7'd5;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({host_gnt, usb_gnt, buf_store, buf_get, buf_flush, lock_err, buf_wdata} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs actual=%b required=0", {host_gnt, usb_gnt, buf_store, buf_get, buf_flush, lock_err, buf_wdata});
         end
         checks++;
         if ({host_gnt_cnt, usb_gnt_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts actual=%h required=0", {host_gnt_cnt, usb_gnt_cnt});
         end
         next_cycle();
      end
      rst = 1'b0; host_req = 1'b0; usb_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_alternate();
      buffer_occupancy = 7'd10;
      host_req = 1'b1; host_op = OP_STORE; host_wdata = 8'hA0;
      usb_req = 1'b1; usb_op = OP_STORE; usb_wdata = 8'hB0;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) exp_q.push_back(ev_host_store(host_wdata));
         else exp_q.push_back(ev_usb_store(usb_wdata));
         @(negedge clk);
         checks++;
         if ({host_gnt, usb_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL alternate_%0d actual=%b required=%b", i, {host_gnt, usb_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         next_cycle();
         if (i % 2 == 0) host_wdata = host_wdata + 8'd1;
         else usb_wdata = usb_wdata + 8'd1;
      end
      host_req = 1'b0; usb_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_get_empty();
      buffer_occupancy = 7'd0;
      host_req = 1'b1; host_op = OP_GET;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({host_gnt, buf_get} !== 2'b00) begin
            errors++;
            $display("FAIL get_empty_stall actual=%b required=00", {host_gnt, buf_get});
         end
         next_cycle();
      end
      buffer_occupancy = 7'd1;
      exp_q.push_back(ev_host_get());
      @(negedge clk);
      checks++;
      if ({host_gnt, buf_get} !== 2'b11) begin
         errors++;
         $display("FAIL get_first_byte actual=%b required=11", {host_gnt, buf_get});
      end
      next_cycle();
      host_req = 1'b0;
   endtask

   task automatic test_full();
      buffer_occupancy = 7'd64;
      usb_req = 1'b1; usb_op = OP_STORE; usb_wdata = 8'hC5;
      host_req = 1'b1; host_op = OP_GET;
      exp_q.push_back(ev_host_get());
      @(negedge clk);
      checks++;
      if ({host_gnt, usb_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL full_host_get actual=%b required=10", {host_gnt, usb_gnt});
      end
      next_cycle();
      host_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({usb_gnt, buf_store} !== 2'b00) begin
            errors++;
            $display("FAIL full_usb_stall actual=%b required=00", {usb_gnt, buf_store});
         end
         next_cycle();
      end
      buffer_occupancy = 7'd63;
      exp_q.push_back(ev_usb_store(8'hC5));
      @(negedge clk);
      checks++;
      if (usb_gnt !== 1'b1) begin
         errors++;
         $display("FAIL full_usb_resume actual=%b required=1", usb_gnt);
      end
      next_cycle();
      usb_req = 1'b0;
   endtask

   task automatic test_flush();
      logic [2:0] want;
      buffer_occupancy = 7'd10;
      host_req = 1'b1; host_op = OP_STORE; host_wdata = 8'hD0;
      usb_req = 1'b1; usb_op = OP_STORE; usb_wdata = 8'hE0;
      usb_flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         want = (i == 1) ? 3'b001 : 3'b000;
         @(negedge clk);
         checks++;
         if ({host_gnt, usb_gnt, buf_flush} !== want) begin
            errors++;
            $display("FAIL flush_seq_%0d actual=%b required=%b", i, {host_gnt, usb_gnt, buf_flush}, want);
         end
         next_cycle();
         usb_flush = 1'b0;
      end
      exp_q.push_back(ev_host_store(8'hD0));
      @(negedge clk);
      checks++;
      if ({host_gnt, usb_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL flush_host_first actual=%b required=10", {host_gnt, usb_gnt});
      end
      next_cycle();
      host_req = 1'b0;
      exp_q.push_back(ev_usb_store(8'hE0));
      @(negedge clk);
      checks++;
      if (usb_gnt !== 1'b1) begin
         errors++;
         $display("FAIL flush_usb_next actual=%b required=1", usb_gnt);
      end
      next_cycle();
      usb_req = 1'b0;
   endtask

   task automatic test_lock();
      buffer_occupancy = 7'd10;
      host_req = 1'b1; host_op = OP_STORE; host_wdata = 8'h11;
      usb_req = 1'b1; usb_op = OP_STORE; usb_wdata = 8'h00;
      usb_lock = 1'b1;
      // Host waits out the lock cycle plus 255 counted LOCKED cycles.
      for (int n = 0; n < 256; n++) begin
         exp_q.push_back(ev_usb_store(usb_wdata));
         @(negedge clk);
         checks++;
         if ({host_gnt, usb_gnt, lock_err} !== 3'b010) begin
            errors++;
            $display("FAIL lock_hold_%0d actual=%b required=010", n, {host_gnt, usb_gnt, lock_err});
         end
         next_cycle();
         usb_wdata = usb_wdata + 8'd1;
      end
      exp_q.push_back(ev_host_store(8'h11));
      @(negedge clk);
      checks++;
      if ({host_gnt, usb_gnt, lock_err} !== 3'b101) begin
         errors++;
         $display("FAIL lock_timeout actual=%b required=101", {host_gnt, usb_gnt, lock_err});
      end
      next_cycle();
      host_req = 1'b0;
      for (int n = 257; n < 300; n++) begin
         exp_q.push_back(ev_usb_store(usb_wdata));
         @(negedge clk);
         checks++;
         if ({usb_gnt, lock_err} !== 2'b11) begin
            errors++;
            $display("FAIL lock_sticky_%0d actual=%b required=11", n, {usb_gnt, lock_err});
         end
         next_cycle();
         usb_wdata = usb_wdata + 8'd1;
      end
      usb_lock = 1'b0; usb_req = 1'b0;
      next_cycle();
      host_clear = 1'b1;
      @(negedge clk);
      checks++;
      if (lock_err !== 1'b1) begin
         errors++;
         $display("FAIL lock_err_before_clear actual=%b required=1", lock_err);
      end
      next_cycle();
      host_clear = 1'b0;
      @(negedge clk);
      checks++;
      if ({lock_err, buf_flush} !== 2'b01) begin
         errors++;
         $display("FAIL lock_err_cleared actual=%b required=01", {lock_err, buf_flush});
      end
      next_cycle();
      next_cycle();
   endtask

   task automatic test_rst_mid();
      buffer_occupancy = 7'd10;
      host_req = 1'b1; host_op = OP_STORE; host_wdata = 8'h21;
      exp_q.push_back(ev_host_store(8'h21));
      @(negedge clk);
      checks++;
      if (host_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre actual=%b required=1", host_gnt);
      end
      next_cycle();
      host_wdata = 8'h22;
      usb_req = 1'b1; usb_op = OP_STORE; usb_wdata = 8'h31;
      host_clear = 1'b1;
      @(negedge clk);
      checks++;
      if ({host_gnt, usb_gnt, buf_store} !== 3'b000) begin
         errors++;
         $display("FAIL clear_suppress actual=%b required=000", {host_gnt, usb_gnt, buf_store});
      end
      next_cycle();
      host_clear = 1'b0; rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({host_gnt, usb_gnt, buf_store, buf_get, buf_flush} !== 5'b00000) begin
         errors++;
         $display("FAIL rst_mid_quiet actual=%b required=00000", {host_gnt, usb_gnt, buf_store, buf_get, buf_flush});
      end
      next_cycle();
      rst = 1'b0;
      exp_q.push_back(ev_host_store(8'h22));
      @(negedge clk);
      checks++;
      if ({host_gnt, usb_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL rst_mid_ptr actual=%b required=10", {host_gnt, usb_gnt});
      end
      next_cycle();
      host_req = 1'b0;
      exp_q.push_back(ev_usb_store(8'h31));
      @(negedge clk);
      checks++;
      if (usb_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_usb actual=%b required=1", usb_gnt);
      end
      next_cycle();
      usb_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_stats();
`ifdef BUFFER_ARB_STATS_EN
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      buffer_occupancy = 7'd10;
      host_req = 1'b1; host_op = OP_STORE; host_wdata = 8'h5A;
      for (int i = 0; i < 70000; i++) begin
         exp_q.push_back(ev_host_store(8'h5A));
         next_cycle();
         if (i == 99) begin
            checks++;
            if (host_gnt_cnt !== 16'd100) begin
               errors++;
               $display("FAIL stats_count_100 actual=%0d required=100", host_gnt_cnt);
            end
         end
      end
      host_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({host_gnt_cnt, usb_gnt_cnt} !== {16'hFFFF, 16'h0000}) begin
         errors++;
         $display("FAIL stats_saturate actual=%h required=ffff0000", {host_gnt_cnt, usb_gnt_cnt});
      end
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (host_gnt_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL stats_reset actual=%h required=0000", host_gnt_cnt);
      end
      next_cycle();
`else
      @(negedge clk);
      checks++;
      if ({host_gnt_cnt, usb_gnt_cnt} !== 32'd0) begin
         errors++;
         $display("FAIL stats_tied_off actual=%h required=0", {host_gnt_cnt, usb_gnt_cnt});
      end
      next_cycle();
`endif
   endtask

   initial begin
      #1;
      test_reset();
      test_alternate();
      test_get_empty();
      test_full();
      test_flush();
      test_lock();
      test_rst_mid();
      test_stats();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
